// File: rtl/program_setter_if.sv
// program_setter_if
//   Groups the front-panel key inputs, the system state and the program-word
//   outputs of program_setter into one bundle.
//   master : drives state and the raw keys, observes the program word.
//   slave  : the program_setter block itself.
interface program_setter_if;
  logic [2:0]  state;       // system state, same clock domain as the setter
  logic        btn_up;      // raw keys, active high, asynchronous
  logic        btn_down;
  logic        btn_next;
  logic        btn_preset;
  logic [25:0] data;        // program word
  logic [2:0]  sel;         // field currently being edited
  logic [1:0]  preset_idx;  // last preset loaded
  logic        cfg_err;     // program word is all zeros

  modport master (
    output state, btn_up, btn_down, btn_next, btn_preset,
    input  data, sel, preset_idx, cfg_err
  );

  modport slave (
    input  state, btn_up, btn_down, btn_next, btn_preset,
    output data, sel, preset_idx, cfg_err
  );
endinterface

// File: rtl/program_setter.sv
// program_setter
//   Front-panel program entry for the washing-machine controller. Synchronises
//   four push-buttons, edge-detects them, auto-repeats held up/down keys and
//   edits one digit field of the 26-bit program word while in the set state.
//   In the begin state the selected preset is reloaded every cycle; in every
//   other state the word, field select and preset index hold.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset, synchronous release
//     bus    : program_setter_if.slave (state, keys in; data, sel,
//              preset_idx, cfg_err out)
//
//   Auto-repeat FSM:
//     state     | meaning
//     RP_IDLE   | no up/down key being tracked
//     RP_DELAY  | initial step taken, waiting REPEAT_DELAY cycles of hold
//     RP_REPEAT | stepping every REPEAT_RATE cycles while the key is held
module program_setter #(
  parameter logic [25:0] PRESET0      = 26'h0A4_9249,
  parameter logic [25:0] PRESET1      = 26'h0C2_4A49,
  parameter logic [25:0] PRESET2      = 26'h1E4_9292,
  parameter logic [25:0] PRESET3      = 26'h029_2040,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input logic            clk,
  input logic            rst_n,
  program_setter_if.slave bus
);

  localparam logic [2:0] ST_BEGIN = 3'd1;
  localparam logic [2:0] ST_SET   = 3'd2;

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rp_state_e;

  // key vector order: {preset, next, down, up}
  logic [3:0] key_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] sync3_q, sync3_d;
  logic [3:0] key_edge;

  logic [25:0] data_q, data_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  preset_idx_q, preset_idx_d;

  rp_state_e        rp_q, rp_d;
  logic             rp_key_q, rp_key_d;   // 0 = up, 1 = down
  logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;

  logic in_set;
  logic held;
  logic rep_fire;
  logic up_act, down_act;
  logic do_up, do_down, do_next, do_preset;
  logic [3:0] fld, fld_max, fld_new;
  logic [1:0] preset_inc;

  function automatic logic [25:0] preset_word(input logic [1:0] idx);
    logic [25:0] w;
    case (idx)
      2'd0:    w = PRESET0;
      2'd1:    w = PRESET1;
      2'd2:    w = PRESET2;
      default: w = PRESET3;
    endcase
    return w;
  endfunction

  assign key_raw = {bus.btn_preset, bus.btn_next, bus.btn_down, bus.btn_up};

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  // sync3 is the previous synchronised level, so the pulse lasts one cycle
  assign key_edge = sync2_q & ~sync3_q;

  assign in_set   = (bus.state == ST_SET);
  assign held     = rp_key_q ? sync2_q[1] : sync2_q[0];
  assign rep_fire = (rp_q != RP_IDLE) && held && (rp_cnt_q == '0);

  assign up_act   = key_edge[0] | (rep_fire & ~rp_key_q);
  assign down_act = key_edge[1] | (rep_fire &  rp_key_q);

  // one action per cycle: up > down > next > preset
  always_comb begin
    do_up     = in_set & up_act;
    do_down   = in_set & down_act & ~up_act;
    do_next   = in_set & key_edge[2] & ~up_act & ~down_act;
    do_preset = in_set & key_edge[3] & ~up_act & ~down_act & ~key_edge[2];
  end

  always_comb begin
    rp_d     = rp_q;
    rp_key_d = rp_key_q;
    rp_cnt_d = rp_cnt_q;
    if (!in_set) begin
      rp_d = RP_IDLE;
    end else if (do_up && key_edge[0]) begin
      rp_d     = RP_DELAY;
      rp_key_d = 1'b0;
      rp_cnt_d = DELAY_LOAD;
    end else if (do_down && key_edge[1]) begin
      rp_d     = RP_DELAY;
      rp_key_d = 1'b1;
      rp_cnt_d = DELAY_LOAD;
    end else begin
      case (rp_q)
        RP_DELAY, RP_REPEAT: begin
          if (!held) begin
            rp_d = RP_IDLE;
          end else if (rp_cnt_q == '0) begin
            rp_d     = RP_REPEAT;
            rp_cnt_d = RATE_LOAD;
          end else begin
            rp_cnt_d = rp_cnt_q - 1'b1;
          end
        end
        default: rp_d = RP_IDLE;
      endcase
    end
  end

  always_comb begin
    fld     = '0;
    fld_max = '0;
    case (sel_q)
      3'd0:    begin fld = {1'b0, data_q[25:23]}; fld_max = 4'd5; end
      3'd1:    begin fld = data_q[22:19];         fld_max = 4'd9; end
      3'd2:    begin fld = {1'b0, data_q[18:16]}; fld_max = 4'd7; end
      3'd3:    begin fld = {1'b0, data_q[15:13]}; fld_max = 4'd7; end
      3'd4:    begin fld = {1'b0, data_q[12:10]}; fld_max = 4'd7; end
      3'd5:    begin fld = data_q[9:6];           fld_max = 4'd9; end
      3'd6:    begin fld = {1'b0, data_q[5:3]};   fld_max = 4'd7; end
      default: begin fld = {1'b0, data_q[2:0]};   fld_max = 4'd7; end
    endcase
  end

  // out-of-range digits (possible in a preset) snap to 0 going up, max going down
  always_comb begin
    if (do_up) begin
      fld_new = (fld >= fld_max) ? 4'd0 : fld + 4'd1;
    end else begin
      fld_new = ((fld == 4'd0) || (fld > fld_max)) ? fld_max : fld - 4'd1;
    end
  end

  assign preset_inc = preset_idx_q + 2'd1;

  always_comb begin
    data_d       = data_q;
    sel_d        = sel_q;
    preset_idx_d = preset_idx_q;
    if (bus.state == ST_BEGIN) begin
      data_d = preset_word(preset_idx_q);
      sel_d  = 3'd0;
    end else if (do_up || do_down) begin
      case (sel_q)
        3'd0:    data_d[25:23] = fld_new[2:0];
        3'd1:    data_d[22:19] = fld_new;
        3'd2:    data_d[18:16] = fld_new[2:0];
        3'd3:    data_d[15:13] = fld_new[2:0];
        3'd4:    data_d[12:10] = fld_new[2:0];
        3'd5:    data_d[9:6]   = fld_new;
        3'd6:    data_d[5:3]   = fld_new[2:0];
        default: data_d[2:0]   = fld_new[2:0];
      endcase
    end else if (do_next) begin
      sel_d = sel_q + 3'd1;
    end else if (do_preset) begin
      preset_idx_d = preset_inc;
      data_d       = preset_word(preset_inc);
      sel_d        = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      data_q       <= PRESET0;
      sel_q        <= '0;
      preset_idx_q <= '0;
      rp_q         <= RP_IDLE;
      rp_key_q     <= 1'b0;
      rp_cnt_q     <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      preset_idx_q <= preset_idx_d;
      rp_q         <= rp_d;
      rp_key_q     <= rp_key_d;
      rp_cnt_q     <= rp_cnt_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.sel        = sel_q;
  assign bus.preset_idx = preset_idx_q;
  assign bus.cfg_err    = (data_q == '0);

endmodule

// File: tb/tb_program_setter.sv
module tb_program_setter;

  localparam logic [25:0] P0 = 26'h0A4_9249;
  localparam logic [25:0] P1 = 26'h0C2_4A49;
  localparam logic [25:0] P2 = 26'h1E4_9292;
  localparam logic [25:0] P3 = 26'h029_2040;

  localparam logic [3:0] K_UP   = 4'b0001;
  localparam logic [3:0] K_DN   = 4'b0010;
  localparam logic [3:0] K_NXT  = 4'b0100;
  localparam logic [3:0] K_PRE  = 4'b1000;
  localparam logic [3:0] K_NONE = 4'b0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  program_setter_if bus();
  program_setter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [3:0]  btn;
    logic [25:0] d;
    logic [2:0]  s;
    logic [1:0]  p;
  } vec_t;

  vec_t        tbl[$];
  logic [25:0] w;
  logic [2:0]  ws;
  logic [1:0]  wp;

  function automatic logic [25:0] ins(input logic [25:0] x, input int f, input int v);
    logic [25:0] r;
    logic [3:0]  v4;
    r  = x;
    v4 = 4'(v);
    case (f)
      0:       r[25:23] = v4[2:0];
      1:       r[22:19] = v4;
      2:       r[18:16] = v4[2:0];
      3:       r[15:13] = v4[2:0];
      4:       r[12:10] = v4[2:0];
      5:       r[9:6]   = v4;
      6:       r[5:3]   = v4[2:0];
      default: r[2:0]   = v4[2:0];
    endcase
    return r;
  endfunction

  // steps taken by a key pressed before edge 0 and released before edge h,
  // as seen after edge c (first step at 2, repeats at 10, 14, 18, ...)
  function automatic int steps(input int c, input int h);
    int last;
    int n;
    last = (c < h + 1) ? c : h + 1;
    n = 0;
    if (last >= 2)  n = 1;
    if (last >= 10) n = n + (last - 10) / 4 + 1;
    return n;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    bus.btn_up     = b[0];
    bus.btn_down   = b[1];
    bus.btn_next   = b[2];
    bus.btn_preset = b[3];
  endtask

  task automatic add(input string n, input logic [2:0] st, input logic [3:0] b);
    vec_t v;
    v.name = n; v.st = st; v.btn = b; v.d = w; v.s = ws; v.p = wp;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string n, input logic [25:0] d, input logic [2:0] s, input logic [1:0] p);
    chk({n, " data"}, 32'(bus.data), 32'(d));
    chk({n, " sel"}, 32'(bus.sel), 32'(s));
    chk({n, " preset_idx"}, 32'(bus.preset_idx), 32'(p));
    chk({n, " cfg_err"}, 32'(bus.cfg_err), 32'(d == 26'd0));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.state = 3'd0;
    set_btn(K_NONE);
    repeat (3) @(negedge clk);
    check_outs("reset", P0, 3'd0, 2'd0);

    rst_n     = 1'b1;
    bus.state = 3'd1;
    repeat (2) @(negedge clk);
    check_outs("begin", P0, 3'd0, 2'd0);

    // table: field edits in set state, priority, presets, ignored states
    w = P0; ws = 3'd0; wp = 2'd0;
    w = ins(w, 0, 2); add("up f0=2", 3'd2, K_UP);
    w = ins(w, 0, 3); add("up f0=3", 3'd2, K_UP);
    w = ins(w, 0, 4); add("up f0=4", 3'd2, K_UP);
    w = ins(w, 0, 5); add("up f0=5", 3'd2, K_UP);
    w = ins(w, 0, 0); add("up f0 wrap", 3'd2, K_UP);
    w = ins(w, 0, 1); add("up f0=1", 3'd2, K_UP);
    w = ins(w, 0, 0); add("down f0=0", 3'd2, K_DN);
    w = ins(w, 0, 5); add("down f0 wrap", 3'd2, K_DN);
    ws = 3'd1;        add("next sel1", 3'd2, K_NXT);
    w = ins(w, 1, 3); add("down f1=3", 3'd2, K_DN);
    w = ins(w, 1, 4); add("up beats next", 3'd2, K_UP | K_NXT);
    w = ins(w, 1, 5); add("up beats down", 3'd2, K_UP | K_DN);
    w = ins(w, 1, 4); add("down beats next", 3'd2, K_DN | K_NXT);
    ws = 3'd2;        add("next beats preset", 3'd2, K_NXT | K_PRE);
    ws = 3'd3;        add("next sel3", 3'd2, K_NXT);
    ws = 3'd4;        add("next sel4", 3'd2, K_NXT);
    ws = 3'd5;        add("next sel5", 3'd2, K_NXT);
    w = ins(w, 5, 0); add("up f5 wrap", 3'd2, K_UP);
    w = ins(w, 5, 9); add("down f5 wrap", 3'd2, K_DN);
    ws = 3'd6;        add("next sel6", 3'd2, K_NXT);
    ws = 3'd7;        add("next sel7", 3'd2, K_NXT);
    w = ins(w, 7, 2); add("up f7=2", 3'd2, K_UP);
    ws = 3'd0;        add("next sel wrap", 3'd2, K_NXT);
    wp = 2'd1; w = P1; add("preset 1", 3'd2, K_PRE);
    wp = 2'd2; w = P2; add("preset 2", 3'd2, K_PRE);
    add("run all keys", 3'd3, 4'hF);
    add("shutdown up", 3'd0, K_UP);
    add("pause next", 3'd5, K_NXT);
    add("error preset", 3'd4, K_PRE);
    add("finish down", 3'd6, K_DN);
    ws = 3'd1;        add("next sel1 b", 3'd2, K_NXT);
    ws = 3'd2;        add("next sel2 b", 3'd2, K_NXT);
    w = ins(w, 2, 5); add("up f2=5", 3'd2, K_UP);
    w = P2; ws = 3'd0; add("begin reload", 3'd1, K_UP);
    wp = 2'd3; w = P3; add("preset 3", 3'd2, K_PRE);
    wp = 2'd0; w = P0; add("preset wrap", 3'd2, K_PRE);
    w = ins(w, 0, 2); add("up after wrap", 3'd2, K_UP);

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.state = tbl[i].st;
      set_btn(tbl[i].btn);
      @(negedge clk);
      set_btn(K_NONE);
      repeat (4) @(negedge clk);
      check_outs(tbl[i].name, tbl[i].d, tbl[i].s, tbl[i].p);
    end

    // hold down on field 1 through delay and repeat: 4,3,2,1,0,9
    bus.state = 3'd2;
    @(negedge clk);
    set_btn(K_NXT);
    @(negedge clk);
    set_btn(K_NONE);
    repeat (4) @(negedge clk);
    chk("seqA sel", 32'(bus.sel), 32'd1);
    bus.btn_down = 1'b1;
    for (int c = 0; c <= 26; c++) begin
      int v;
      @(negedge clk);
      v = 4 - steps(c, 21);
      if (v < 0) v = v + 10;
      chk($sformatf("hold down c=%0d", c), 32'(bus.data), 32'(ins(w, 1, v)));
      if (c == 20) bus.btn_down = 1'b0;
    end
    w = ins(w, 1, 9);

    // reset in the middle of a held up key, key still held at release
    bus.btn_up = 1'b1;
    for (int c = 0; c <= 15; c++) @(negedge clk);
    chk("hold up before reset", 32'(bus.data), 32'(ins(w, 1, (9 + steps(15, 100)) % 10)));
    rst_n = 1'b0;
    #1;
    check_outs("reset mid-hold", P0, 3'd0, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset hold c=%0d", c), 32'(bus.data), 32'(ins(P0, 0, (1 + steps(c, 16)) % 6)));
      if (c == 15) bus.btn_up = 1'b0;
    end
    w = ins(P0, 0, (1 + steps(40, 16)) % 6);

    // leaving set state before the update edge drops the pending edit
    @(negedge clk);
    bus.btn_up = 1'b1;
    @(negedge clk);
    bus.btn_up = 1'b0;
    @(negedge clk);
    bus.state = 3'd3;
    repeat (4) @(negedge clk);
    chk("state drop pending", 32'(bus.data), 32'(w));
    bus.state = 3'd2;
    repeat (4) @(negedge clk);
    chk("no late edit", 32'(bus.data), 32'(w));

    // leaving set state mid-hold stops repeat; returning does not resume it
    bus.btn_up = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2)  chk("held step", 32'(bus.data), 32'(ins(w, 0, 5)));
      if (c == 5)  bus.state = 3'd3;
      if (c == 14) begin
        chk("state3 stops repeat", 32'(bus.data), 32'(ins(w, 0, 5)));
        bus.state = 3'd2;
      end
      if (c == 30) chk("no resume", 32'(bus.data), 32'(ins(w, 0, 5)));
    end
    bus.btn_up = 1'b0;
    repeat (4) @(negedge clk);
    check_outs("final", ins(w, 0, 5), 3'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
